// File: rtl/err_burst_sched.sv
// Burst error injector for the interleaver-to-RS-decoder byte stream.
// After an accepted start it waits cfg_offset bytes, then corrupts
// cfg_num_bursts bursts of cfg_burst_len bytes separated by cfg_gap_len
// clean bytes. Corrupted bytes are replaced by, or XOR-ed with, cfg_pattern.
module err_burst_sched #(
    parameter int OFS_W = 17,
    parameter int LEN_W = 16,
    parameter int NB_W  = 8,
    parameter int CNT_W = 24
) (
    input  logic             clk_out125M,
    input  logic             sys_rst_n,
    input  logic [7:0]       intlv_out,
    input  logic             intlv_out_sync,
    input  logic             start,
    input  logic [OFS_W-1:0] cfg_offset,
    input  logic [LEN_W-1:0] cfg_burst_len,
    input  logic [LEN_W-1:0] cfg_gap_len,
    input  logic [NB_W-1:0]  cfg_num_bursts,
    input  logic             cfg_xor_mode,
    input  logic [7:0]       cfg_pattern,
    output logic [7:0]       intlv_out_err,
    output logic             err_sync,
    output logic             err_active,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] inj_count
);

    localparam int CW = (OFS_W > LEN_W) ? OFS_W : LEN_W;

    typedef enum logic [1:0] {IDLE, OFFSET, BURST, GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;     // ticks remaining in current state, minus one
    logic [NB_W-1:0]  left_q, left_d;   // bursts remaining, including the current one
    logic [LEN_W-1:0] blen_q, blen_d;
    logic [LEN_W-1:0] gap_q, gap_d;
    logic             xor_q, xor_d;
    logic [7:0]       pat_q, pat_d;
    logic             done_d, abort_d, clr_inj, accept, corrupt;

    logic [7:0]       dout_q;
    logic             sync_q, active_q, done_q, abort_q;
    logic [CNT_W-1:0] inj_q;

    // Next-state logic: schedule sequencing, config capture and abort on sync loss
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        blen_d  = blen_q;
        gap_d   = gap_q;
        xor_d   = xor_q;
        pat_d   = pat_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        clr_inj = 1'b0;
        accept  = start && (state_q == IDLE) && intlv_out_sync;
        corrupt = (state_q == BURST) && intlv_out_sync;

        if (state_q == IDLE) begin
            if (accept) begin
                clr_inj = 1'b1;
                blen_d  = cfg_burst_len;
                gap_d   = cfg_gap_len;
                xor_d   = cfg_xor_mode;
                pat_d   = cfg_pattern;
                left_d  = cfg_num_bursts;
                if (cfg_num_bursts == '0 || cfg_burst_len == '0) begin
                    done_d = 1'b1;
                end else if (cfg_offset == '0) begin
                    state_d = BURST;
                    cnt_d   = CW'(cfg_burst_len - LEN_W'(1));
                end else begin
                    state_d = OFFSET;
                    cnt_d   = CW'(cfg_offset - OFS_W'(1));
                end
            end
        end else if (!intlv_out_sync) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                OFFSET, GAP: begin
                    if (cnt_q == '0) begin
                        state_d = BURST;
                        cnt_d   = CW'(blen_q - LEN_W'(1));
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                BURST: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (left_q == NB_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        left_d = left_q - NB_W'(1);
                        if (gap_q == '0) begin
                            state_d = BURST;
                            cnt_d   = CW'(blen_q - LEN_W'(1));
                        end else begin
                            state_d = GAP;
                            cnt_d   = CW'(gap_q - LEN_W'(1));
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and captured configuration registers
    always_ff @(posedge clk_out125M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            left_q  <= '0;
            blen_q  <= '0;
            gap_q   <= '0;
            xor_q   <= 1'b0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            blen_q  <= blen_d;
            gap_q   <= gap_d;
            xor_q   <= xor_d;
            pat_q   <= pat_d;
        end
    end

    // One-cycle datapath, status pulses and saturating injection counter
    always_ff @(posedge clk_out125M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dout_q   <= '0;
            sync_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            inj_q    <= '0;
        end else begin
            dout_q   <= corrupt ? (xor_q ? (intlv_out ^ pat_q) : pat_q) : intlv_out;
            sync_q   <= intlv_out_sync;
            active_q <= corrupt;
            done_q   <= done_d;
            abort_q  <= abort_d;
            if (clr_inj) begin
                inj_q <= '0;
            end else if (corrupt && inj_q != '1) begin
                inj_q <= inj_q + CNT_W'(1);
            end
        end
    end

    assign intlv_out_err = dout_q;
    assign err_sync      = sync_q;
    assign err_active    = active_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign aborted       = abort_q;
    assign inj_count     = inj_q;

endmodule

// File: tb/tb_err_burst_sched.sv
// Scoreboard bench for err_burst_sched: a position-based reference model
// predicts each output cycle; a negedge monitor pops and compares.
module tb_err_burst_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        sync = 1'b0;
    logic        start = 1'b0;
    logic [16:0] c_off = '0;
    logic [15:0] c_len = '0;
    logic [15:0] c_gap = '0;
    logic [7:0]  c_nb = '0;
    logic        c_xor = 1'b0;
    logic [7:0]  c_pat = '0;
    logic [7:0]  dout;
    logic        esync, eact, busy, done, aborted;
    logic [23:0] inj;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0]  d;
        logic        s;
        logic        a;
        logic        b;
        logic        dn;
        logic        ab;
        logic [23:0] inj;
    } exp_t;

    exp_t sb[$];

    err_burst_sched #(.OFS_W(17), .LEN_W(16), .NB_W(8), .CNT_W(24)) dut (
        .clk_out125M   (clk),
        .sys_rst_n     (rst_n),
        .intlv_out     (din),
        .intlv_out_sync(sync),
        .start         (start),
        .cfg_offset    (c_off),
        .cfg_burst_len (c_len),
        .cfg_gap_len   (c_gap),
        .cfg_num_bursts(c_nb),
        .cfg_xor_mode  (c_xor),
        .cfg_pattern   (c_pat),
        .intlv_out_err (dout),
        .err_sync      (esync),
        .err_active    (eact),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .inj_count     (inj)
    );

    always #5 clk = ~clk;

    // Reference model: a running schedule is a byte position since start;
    // a position is corrupted when it lies inside one of the nb bursts.
    bit       m_run;
    int       m_pos, m_off, m_len, m_gap, m_nb, m_inj;
    bit       m_xor;
    bit [7:0] m_pat;

    function automatic bit in_burst(int p);
        int per, rel;
        if (p < m_off) return 1'b0;
        per = m_len + m_gap;
        rel = p - m_off;
        return ((rel / per) < m_nb) && ((rel % per) < m_len);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_pos = 0;
            m_inj = 0;
            sb.delete();
        end else begin
            exp_t e;
            bit   cor;
            int   last;
            cor   = m_run && sync && in_burst(m_pos);
            e     = '0;
            e.s   = sync;
            e.a   = cor;
            e.d   = cor ? (m_xor ? (din ^ m_pat) : m_pat) : din;
            if (m_run) begin
                if (!sync) begin
                    e.ab  = 1'b1;
                    m_run = 1'b0;
                end else begin
                    if (cor && m_inj < 24'hFFFFFF) m_inj++;
                    last = m_off + (m_nb - 1) * (m_len + m_gap) + m_len - 1;
                    if (m_pos == last) begin
                        e.dn  = 1'b1;
                        m_run = 1'b0;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (start && sync) begin
                m_off = int'(c_off);
                m_len = int'(c_len);
                m_gap = int'(c_gap);
                m_nb  = int'(c_nb);
                m_xor = c_xor;
                m_pat = c_pat;
                m_inj = 0;
                m_pos = 0;
                if (m_nb == 0 || m_len == 0) e.dn = 1'b1;
                else m_run = 1'b1;
            end
            e.b   = m_run;
            e.inj = 24'(m_inj);
            sb.push_back(e);
        end
    end

    // Monitor: outputs must be all-zero while in reset, otherwise match the model
    always @(negedge clk) begin
        exp_t e, a;
        a = '{d: dout, s: esync, a: eact, b: busy, dn: done, ab: aborted, inj: inj};
        if (!rst_n) begin
            total++;
            if (a != '0) begin
                bad++;
                $display("FAIL reset_outputs: got d=%h s=%b a=%b b=%b dn=%b ab=%b inj=%0d, want all zero",
                         a.d, a.s, a.a, a.b, a.dn, a.ab, a.inj);
            end
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (a != e) begin
                bad++;
                $display("FAIL stream_cycle @%0t: got d=%h s=%b a=%b b=%b dn=%b ab=%b inj=%0d, want d=%h s=%b a=%b b=%b dn=%b ab=%b inj=%0d",
                         $time, a.d, a.s, a.a, a.b, a.dn, a.ab, a.inj,
                         e.d, e.s, e.a, e.b, e.dn, e.ab, e.inj);
            end
        end
    end

    task automatic step(input logic [7:0] d, input logic s, input logic st);
        din   = d;
        sync  = s;
        start = st;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic set_cfg(input int off, input int len, input int gap, input int nb,
                           input bit x, input logic [7:0] pat);
        c_off = 17'(off);
        c_len = 16'(len);
        c_gap = 16'(gap);
        c_nb  = 8'(nb);
        c_xor = x;
        c_pat = pat;
    endtask

    task automatic stream(input int n, input int drop_pct, input int start_pct);
        repeat (n) begin
            step(8'($urandom), ($urandom_range(99) >= drop_pct),
                 ($urandom_range(99) < start_pct));
        end
    endtask

    initial begin
        logic [7:0] b;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h00, 1'b1, 1'b0);

        // T1: offset 3, len 2, gap 1, three bursts, replace with 00
        set_cfg(3, 2, 1, 3, 1'b0, 8'h00);
        b = 8'h01;
        step(b, 1'b1, 1'b1);
        repeat (14) begin
            b = b + 8'd1;
            step(b, 1'b1, 1'b0);
        end

        // T2: XOR FF over A5, single burst of 4 at offset 0
        set_cfg(0, 4, 0, 1, 1'b1, 8'hFF);
        repeat (7) step(8'hA5, 1'b1, (b == 8'h0F));
        b = 8'h00;

        // T3: back-to-back bursts with zero gap
        set_cfg(1, 3, 0, 2, 1'b0, 8'h3C);
        step(8'h11, 1'b1, 1'b1);
        stream(10, 0, 0);

        // T4: sync lost at byte 1 of the second burst
        set_cfg(5, 4, 2, 3, 1'b0, 8'hEE);
        step(8'h22, 1'b1, 1'b1);
        stream(12, 0, 0);
        step(8'h33, 1'b0, 1'b0);
        stream(6, 0, 0);

        // T5: degenerate schedules, then start while busy with new config
        set_cfg(4, 3, 1, 0, 1'b0, 8'h55);
        step(8'h44, 1'b1, 1'b1);
        stream(3, 0, 0);
        set_cfg(2, 0, 1, 2, 1'b0, 8'h55);
        step(8'h45, 1'b1, 1'b1);
        stream(3, 0, 0);
        step(8'h46, 1'b0, 1'b1);
        stream(2, 0, 0);
        set_cfg(2, 3, 1, 2, 1'b1, 8'h0F);
        step(8'h47, 1'b1, 1'b1);
        stream(2, 0, 0);
        set_cfg(0, 1, 0, 1, 1'b0, 8'h99);
        step(8'h48, 1'b1, 1'b1);
        stream(12, 0, 0);

        // T6: async reset mid-burst, then a fresh schedule
        set_cfg(0, 8, 0, 1, 1'b0, 8'hAA);
        step(8'h50, 1'b1, 1'b1);
        stream(3, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_cfg(1, 2, 1, 2, 1'b1, 8'h81);
        step(8'h60, 1'b1, 1'b1);
        stream(10, 0, 0);

        // Randomized schedules with occasional sync drops and stray starts
        for (int i = 0; i < 40; i++) begin
            set_cfg($urandom_range(6), $urandom_range(4), $urandom_range(3),
                    $urandom_range(3), 1'($urandom), 8'($urandom));
            step(8'($urandom), 1'b1, 1'b1);
            set_cfg($urandom_range(6), $urandom_range(4), $urandom_range(3),
                    $urandom_range(3), 1'($urandom), 8'($urandom));
            stream($urandom_range(30, 5), 3, 5);
        end

        stream(4, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
